// File: rtl/lcd_byte_writer.sv
`default_nettype none
// ============================================================================
// Module      : lcd_byte_writer
// Description : 4-bit HD44780-style LCD writer with power-up init sequence
//               and byte writes split into high/low nibble strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_byte_writer #(
    parameter int unsigned T_PWRUP = 750000,
    parameter int unsigned T_INIT1 = 205000,
    parameter int unsigned T_INIT2 = 5000,
    parameter int unsigned T_SETUP = 2,
    parameter int unsigned T_EPW   = 12,
    parameter int unsigned T_NIB   = 50,
    parameter int unsigned T_CMD   = 2000,
    parameter int unsigned T_CLR   = 82000
) (
    input  logic       CCLK,
    input  logic       RST,
    input  logic       req_valid,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       req_ready,
    output logic       init_done,
    output logic       LCDRS,
    output logic       LCDRW,
    output logic       LCDE,
    output logic [3:0] LCDDAT
);

    // State encoding
    localparam logic [3:0] c_pwr       = 4'd0;
    localparam logic [3:0] c_init_su   = 4'd1;
    localparam logic [3:0] c_init_e    = 4'd2;
    localparam logic [3:0] c_init_wait = 4'd3;
    localparam logic [3:0] c_idle      = 4'd4;
    localparam logic [3:0] c_hi_su     = 4'd5;
    localparam logic [3:0] c_hi_e      = 4'd6;
    localparam logic [3:0] c_gap       = 4'd7;
    localparam logic [3:0] c_lo_su     = 4'd8;
    localparam logic [3:0] c_lo_e      = 4'd9;
    localparam logic [3:0] c_post      = 4'd10;

    // Terminal counts: a state of duration N exits when the counter reads N-1
    localparam logic [19:0] c_pwrup_m1 = 20'(T_PWRUP - 1);
    localparam logic [19:0] c_init1_m1 = 20'(T_INIT1 - 1);
    localparam logic [19:0] c_init2_m1 = 20'(T_INIT2 - 1);
    localparam logic [19:0] c_setup_m1 = 20'(T_SETUP - 1);
    localparam logic [19:0] c_epw_m1   = 20'(T_EPW - 1);
    localparam logic [19:0] c_nib_m1   = 20'(T_NIB - 1);
    localparam logic [19:0] c_cmd_m1   = 20'(T_CMD - 1);
    localparam logic [19:0] c_clr_m1   = 20'(T_CLR - 1);

    logic [3:0]  r_state;
    logic [19:0] r_cnt;
    logic [1:0]  r_istep;
    logic        r_rs;
    logic [7:0]  r_data;
    logic        r_ready;
    logic        r_init_done;
    logic        r_lcde;
    logic        r_lcdrs;
    logic [3:0]  r_lcddat;

    logic [3:0]  w_state_nxt;
    logic [19:0] w_cnt_nxt;
    logic [1:0]  w_istep_nxt;
    logic [19:0] w_dur_m1;
    logic [19:0] w_wait_m1;
    logic        w_last;
    logic        w_accept;
    logic        w_is_clr;
    logic        w_rs_src;
    logic [7:0]  w_data_src;
    logic        w_lcde_nxt;
    logic        w_lcdrs_nxt;
    logic [3:0]  w_lcddat_nxt;

    assign w_accept   = (r_state == c_idle) && r_ready && req_valid;
    // On the accepting edge the byte registers are not loaded yet, so the
    // first registered nibble comes straight from the request inputs.
    assign w_rs_src   = w_accept ? req_rs   : r_rs;
    assign w_data_src = w_accept ? req_data : r_data;

    // Clear display and return home need the long post-byte wait
    assign w_is_clr = !r_rs && ((r_data == 8'h01) || (r_data == 8'h02) || (r_data == 8'h03));

    always_comb begin
        w_wait_m1 = c_cmd_m1;
        case (r_istep)
            2'd0:    w_wait_m1 = c_init1_m1;
            2'd1:    w_wait_m1 = c_init2_m1;
            default: w_wait_m1 = c_cmd_m1;
        endcase
    end

    always_comb begin
        w_dur_m1 = '0;
        case (r_state)
            c_pwr:                        w_dur_m1 = c_pwrup_m1;
            c_init_su, c_hi_su, c_lo_su:  w_dur_m1 = c_setup_m1;
            c_init_e, c_hi_e, c_lo_e:     w_dur_m1 = c_epw_m1;
            c_init_wait:                  w_dur_m1 = w_wait_m1;
            c_gap:                        w_dur_m1 = c_nib_m1;
            c_post:                       w_dur_m1 = w_is_clr ? c_clr_m1 : c_cmd_m1;
            default:                      w_dur_m1 = '0;
        endcase
    end

    assign w_last = (r_cnt == w_dur_m1);

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_istep_nxt = r_istep;
        case (r_state)
            c_pwr:       if (w_last) w_state_nxt = c_init_su;
            c_init_su:   if (w_last) w_state_nxt = c_init_e;
            c_init_e:    if (w_last) w_state_nxt = c_init_wait;
            c_init_wait: begin
                if (w_last) begin
                    if (r_istep == 2'd3) begin
                        w_state_nxt = c_idle;
                    end else begin
                        w_istep_nxt = r_istep + 2'd1;
                        w_state_nxt = c_init_su;
                    end
                end
            end
            c_idle:      if (w_accept) w_state_nxt = c_hi_su;
            c_hi_su:     if (w_last) w_state_nxt = c_hi_e;
            c_hi_e:      if (w_last) w_state_nxt = c_gap;
            c_gap:       if (w_last) w_state_nxt = c_lo_su;
            c_lo_su:     if (w_last) w_state_nxt = c_lo_e;
            c_lo_e:      if (w_last) w_state_nxt = c_post;
            c_post:      if (w_last) w_state_nxt = c_idle;
            default:     w_state_nxt = c_pwr;
        endcase
    end

    // The counter is held at zero in IDLE so it can never wrap while waiting
    always_comb begin
        w_cnt_nxt = r_cnt + 20'd1;
        if ((w_state_nxt != r_state) || (r_state == c_idle)) begin
            w_cnt_nxt = '0;
        end
    end

    // Outputs are decoded from the next state and registered with it
    always_comb begin
        w_lcde_nxt   = 1'b0;
        w_lcdrs_nxt  = 1'b0;
        w_lcddat_nxt = 4'h0;
        case (w_state_nxt)
            c_init_su, c_init_wait: begin
                w_lcddat_nxt = (w_istep_nxt == 2'd3) ? 4'h2 : 4'h3;
            end
            c_init_e: begin
                w_lcde_nxt   = 1'b1;
                w_lcddat_nxt = (w_istep_nxt == 2'd3) ? 4'h2 : 4'h3;
            end
            c_hi_su, c_gap: begin
                w_lcdrs_nxt  = w_rs_src;
                w_lcddat_nxt = w_data_src[7:4];
            end
            c_hi_e: begin
                w_lcde_nxt   = 1'b1;
                w_lcdrs_nxt  = w_rs_src;
                w_lcddat_nxt = w_data_src[7:4];
            end
            c_lo_su, c_post: begin
                w_lcdrs_nxt  = w_rs_src;
                w_lcddat_nxt = w_data_src[3:0];
            end
            c_lo_e: begin
                w_lcde_nxt   = 1'b1;
                w_lcdrs_nxt  = w_rs_src;
                w_lcddat_nxt = w_data_src[3:0];
            end
            default: begin
                w_lcde_nxt   = 1'b0;
                w_lcdrs_nxt  = 1'b0;
                w_lcddat_nxt = 4'h0;
            end
        endcase
    end

    always_ff @(posedge CCLK) begin
        if (RST) begin
            r_state     <= c_pwr;
            r_cnt       <= '0;
            r_istep     <= '0;
            r_rs        <= 1'b0;
            r_data      <= '0;
            r_ready     <= 1'b0;
            r_init_done <= 1'b0;
            r_lcde      <= 1'b0;
            r_lcdrs     <= 1'b0;
            r_lcddat    <= 4'h0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_istep     <= w_istep_nxt;
            if (w_accept) begin
                r_rs   <= req_rs;
                r_data <= req_data;
            end
            r_ready     <= (w_state_nxt == c_idle);
            r_init_done <= r_init_done | (w_state_nxt == c_idle);
            r_lcde      <= w_lcde_nxt;
            r_lcdrs     <= w_lcdrs_nxt;
            r_lcddat    <= w_lcddat_nxt;
        end
    end

    assign req_ready = r_ready;
    assign init_done = r_init_done;
    assign LCDRS     = r_lcdrs;
    assign LCDRW     = 1'b0;
    assign LCDE      = r_lcde;
    assign LCDDAT    = r_lcddat;

endmodule
`default_nettype wire

// File: tb/tb_lcd_byte_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_byte_writer
// Description : Directed self-checking bench for lcd_byte_writer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_byte_writer;

    logic       CCLK = 1'b0;
    logic       RST = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_rs = 1'b0;
    logic [7:0] req_data = 8'h00;
    logic       req_ready;
    logic       init_done;
    logic       LCDRS;
    logic       LCDRW;
    logic       LCDE;
    logic [3:0] LCDDAT;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // Pulse log filled by the monitor below
    logic [3:0] q_dat[$];
    logic       q_rs[$];
    int         q_rise[$];
    int         q_w[$];
    int         cur_w = 0;
    int         unstable = 0;
    logic       prev_e = 1'b0;
    logic       prev_rs = 1'b0;
    logic [3:0] prev_dat = 4'h0;

    lcd_byte_writer #(
        .T_PWRUP(20), .T_INIT1(10), .T_INIT2(5), .T_SETUP(2),
        .T_EPW(3), .T_NIB(4), .T_CMD(6), .T_CLR(15)
    ) dut (
        .CCLK(CCLK),
        .RST(RST),
        .req_valid(req_valid),
        .req_rs(req_rs),
        .req_data(req_data),
        .req_ready(req_ready),
        .init_done(init_done),
        .LCDRS(LCDRS),
        .LCDRW(LCDRW),
        .LCDE(LCDE),
        .LCDDAT(LCDDAT)
    );

    always #5 CCLK = ~CCLK;

    always @(posedge CCLK) cyc <= cyc + 1;

    always @(negedge CCLK) begin
        if (LCDE === 1'b1 && prev_e !== 1'b1) begin
            q_dat.push_back(LCDDAT);
            q_rs.push_back(LCDRS);
            q_rise.push_back(cyc);
            cur_w = 1;
        end else if (LCDE === 1'b1) begin
            cur_w++;
            if (LCDDAT !== prev_dat || LCDRS !== prev_rs) unstable++;
        end else if (prev_e === 1'b1) begin
            q_w.push_back(cur_w);
        end
        prev_e   = LCDE;
        prev_rs  = LCDRS;
        prev_dat = LCDDAT;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge CCLK);
        @(negedge CCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        q_dat.delete();
        q_rs.delete();
        q_rise.delete();
        q_w.delete();
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_lcde"}, 32'(LCDE), 32'd0);
        chk({tag, "_lcdrs"}, 32'(LCDRS), 32'd0);
        chk({tag, "_lcddat"}, 32'(LCDDAT), 32'd0);
        chk({tag, "_lcdrw"}, 32'(LCDRW), 32'd0);
    endtask

    // Called just after RST is dropped; checks the whole init sequence
    task automatic init_check(input string tag);
        int rel;
        int n;
        int exp_rise[4];
        logic [3:0] exp_nib[4];
        exp_rise = '{22, 37, 47, 58};
        exp_nib  = '{4'h3, 4'h3, 4'h3, 4'h2};
        rel = cyc;
        n = 0;
        while (init_done !== 1'b1 && n < 1000) begin
            chk({tag, "_ready_before_done"}, 32'(req_ready), 32'd0);
            n++;
            tick();
        end
        chk({tag, "_done_at"}, 32'(cyc - rel), 32'd67);
        chk({tag, "_ready_with_done"}, 32'(req_ready), 32'd1);
        chk({tag, "_npulses"}, 32'(q_dat.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_dat%0d", tag, i), 32'(q_dat[i]), 32'(exp_nib[i]));
            chk($sformatf("%s_rs%0d", tag, i), 32'(q_rs[i]), 32'd0);
            chk($sformatf("%s_w%0d", tag, i), 32'(q_w[i]), 32'd3);
            chk($sformatf("%s_rise%0d", tag, i), 32'(q_rise[i] - rel), 32'(exp_rise[i]));
        end
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (req_ready !== 1'b1 && n < 200) begin
            n++;
            tick();
        end
        chk({tag, "_ready_wait"}, 32'(req_ready), 32'd1);
    endtask

    // Counts ready-low cycles starting at the cycle after the accepting edge
    task automatic count_busy(input string tag, input int exp_low);
        int n;
        n = 0;
        while (req_ready !== 1'b1 && n < 200) begin
            n++;
            tick();
        end
        chk({tag, "_busy"}, 32'(n), 32'(exp_low));
    endtask

    task automatic send_byte(input string tag, input logic rs, input logic [7:0] d, input int exp_low);
        int acc;
        wait_ready(tag);
        clear_log();
        req_valid = 1'b1;
        req_rs    = rs;
        req_data  = d;
        tick();
        acc = cyc;
        // Scramble inputs: the accepted byte must already be captured
        req_valid = 1'b0;
        req_rs    = ~rs;
        req_data  = ~d;
        chk({tag, "_accepted"}, 32'(req_ready), 32'd0);
        count_busy(tag, exp_low);
        chk({tag, "_npulses"}, 32'(q_dat.size()), 32'd2);
        chk({tag, "_hi"}, 32'(q_dat[0]), 32'(d[7:4]));
        chk({tag, "_lo"}, 32'(q_dat[1]), 32'(d[3:0]));
        chk({tag, "_rs_hi"}, 32'(q_rs[0]), 32'(rs));
        chk({tag, "_rs_lo"}, 32'(q_rs[1]), 32'(rs));
        chk({tag, "_w_hi"}, 32'(q_w[0]), 32'd3);
        chk({tag, "_w_lo"}, 32'(q_w[1]), 32'd3);
        chk({tag, "_hi_rise"}, 32'(q_rise[0] - acc), 32'd2);
        chk({tag, "_lo_gap"}, 32'(q_rise[1] - q_rise[0]), 32'd9);
        chk_idle_outputs({tag, "_idle"});
    endtask

    initial begin
        logic [7:0] b2b[3];
        b2b = '{8'h48, 8'h49, 8'h21};

        // Reset state
        tick();
        tick();
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_done", 32'(init_done), 32'd0);
        chk_idle_outputs("rst");

        // Init with no requests
        clear_log();
        RST = 1'b0;
        init_check("init");
        chk_idle_outputs("init_idle");

        // Data byte, clear-class commands and their controls
        send_byte("data41", 1'b1, 8'h41, 20);
        send_byte("clr01", 1'b0, 8'h01, 29);
        send_byte("data01", 1'b1, 8'h01, 20);
        send_byte("home03", 1'b0, 8'h03, 29);
        send_byte("cmd00", 1'b0, 8'h00, 20);
        send_byte("cmd04", 1'b0, 8'h04, 20);

        // Back-to-back with req_valid held high
        wait_ready("b2b");
        clear_log();
        req_valid = 1'b1;
        req_rs    = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req_data = b2b[k];
            if (k == 0) begin
                chk("b2b_ready0", 32'(req_ready), 32'd1);
            end
            tick();
            chk($sformatf("b2b_acc%0d", k), 32'(req_ready), 32'd0);
            if (k == 2) req_valid = 1'b0;
            count_busy($sformatf("b2b_%0d", k), 20);
        end
        repeat (10) tick();
        chk("b2b_npulses", 32'(q_dat.size()), 32'd6);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("b2b_hi%0d", k), 32'(q_dat[2*k]), 32'(b2b[k][7:4]));
            chk($sformatf("b2b_lo%0d", k), 32'(q_dat[2*k+1]), 32'(b2b[k][3:0]));
        end
        chk_idle_outputs("b2b_idle");

        // Reset during the high-nibble strobe
        wait_ready("midrst");
        clear_log();
        req_valid = 1'b1;
        req_rs    = 1'b1;
        req_data  = 8'hA5;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        chk("midrst_in_hi_e", 32'(LCDE), 32'd1);
        chk("midrst_hi_dat", 32'(LCDDAT), 32'hA);
        RST = 1'b1;
        tick();
        chk("midrst_ready", 32'(req_ready), 32'd0);
        chk("midrst_done", 32'(init_done), 32'd0);
        chk_idle_outputs("midrst");
        tick();
        chk("midrst_npulses", 32'(q_dat.size()), 32'd1);
        clear_log();
        RST = 1'b0;
        init_check("reinit");

        // Request pending from reset release
        RST = 1'b1;
        tick();
        tick();
        clear_log();
        req_valid = 1'b1;
        req_rs    = 1'b1;
        req_data  = 8'h5A;
        RST = 1'b0;
        init_check("earlyreq");
        tick();
        chk("earlyreq_acc", 32'(req_ready), 32'd0);
        req_valid = 1'b0;
        count_busy("earlyreq", 20);
        chk("earlyreq_npulses", 32'(q_dat.size()), 32'd6);
        chk("earlyreq_hi", 32'(q_dat[4]), 32'h5);
        chk("earlyreq_lo", 32'(q_dat[5]), 32'hA);
        chk("earlyreq_rs", 32'(q_rs[4]), 32'd1);

        chk("strobe_stable", 32'(unstable), 32'd0);
        chk("lcdrw_final", 32'(LCDRW), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
